sorted_pkt_checker: RTL and testbench
=====================================

// Module: sorted_pkt_checker
// PURPOSE
//  Avalon-ST packet receiver for the sorter's source port: accepts packets, checks framing,
//  length and non-decreasing order, and reports per-packet status plus running counters.
//  Sits downstream of the sorting block in the datapath/bench harness.
//  Generates optional pseudo-random backpressure on its own ready.
// PARAMETERS
//  DWIDTH       16    data beat width, unsigned compare
//  MAX_PKT_LEN  250   largest legal packet in beats
//  LFSR_SEED    16'hACE1  non-zero backpressure LFSR seed
//  CWIDTH       16    width of packet/error counters
// PORTS
//  clk_i            in   1               single clock
//  rst_ni           in   1               asynchronous active-low reset
//  snk_data_i       in   DWIDTH          beat data
//  snk_startofpacket_i in 1              first beat
//  snk_endofpacket_i in  1               last beat
//  snk_valid_i      in   1               beat valid
//  snk_ready_o      out  1               ready (registered)
//  cfg_bp_en_i      in   1               1 = random backpressure, 0 = always ready
//  stat_valid_o     out  1               1-cycle pulse: status fields valid
//  stat_len_o       out  $clog2(MAX_PKT_LEN)+1  beats in finished packet (saturates)
//  stat_order_err_o out  1               packet had data[k] < data[k-1]
//  stat_len_err_o   out  1               packet longer than MAX_PKT_LEN
//  stat_frame_err_o out  1               SOP seen mid-packet (packet truncated)
//  pkt_cnt_o        out  CWIDTH          packets completed (wraps)
//  err_cnt_o        out  CWIDTH          packets with any error (wraps)
//  orphan_cnt_o     out  CWIDTH          beats accepted outside a packet (wraps)
// BEHAVIOUR
//  - Beat accepted iff snk_valid_i & snk_ready_o. Unaccepted beats ignored entirely.
//  - Reset: all outputs 0 except snk_ready_o=1; FSM IDLE_S; LFSR=LFSR_SEED.
//  - snk_ready_o: registered; cfg_bp_en_i=0 -> 1 next cycle; =1 -> lfsr[1]|lfsr[0]
//    (~75% duty). 16-bit Fibonacci LFSR taps 16,14,13,11, steps every cycle.
//  - FSM IDLE_S: accepted SOP -> store data as prev, len=1; if EOP same beat ->
//    finish (single-beat packet, never order error) else RECV_S. Accepted non-SOP
//    -> orphan_cnt_o+1, stay IDLE_S.
//  - RECV_S: accepted beat: len+1 (saturate at all-ones); if data<prev set order flag;
//    prev<=data; if len would exceed MAX_PKT_LEN set len flag. EOP -> finish, IDLE_S.
//    Accepted SOP (with or without EOP): finish current packet with frame flag set,
//    then restart as new packet from this beat (same-cycle, no beat lost).
//  - Finish: cycle after the finishing beat stat_valid_o=1 for exactly one cycle with
//    len/flags of that packet; status fields hold until next stat_valid_o.
//    pkt_cnt_o+1 same cycle; err_cnt_o+1 if any flag. Flags cleared for next packet.
//  - SOP+EOP restart case in RECV_S: two finishes back-to-back -> stat_valid_o high
//    two consecutive cycles, counters +1 each cycle.
//  - Compare: unsigned, equal values legal (non-decreasing).
//  - Counters wrap modulo 2**CWIDTH; stat_len_o saturates, never wraps.
//  - Reset asserted mid-packet: packet discarded, no stat_valid_o, counters cleared.
//  - cfg_bp_en_i change takes effect on ready the following cycle; no packet impact.
// STRUCTURE
//  - Package avst_pkg: state enum (IDLE_S, RECV_S), LFSR tap constant, status struct
//    {len, order_err, len_err, frame_err}.
//  - Sub-module bp_lfsr (16-bit LFSR, seed param, enable-less) drives ready pattern.
//  - Remainder in one file: FSM, prev register, length/flag logic, counters.
// TESTING
//  - bp off, SOP/3/5/5/9/EOP -> stat_valid_o 1 cycle after EOP, len=4, no flags, pkt_cnt=1.
//  - single beat SOP+EOP data 7 -> len=1, no flags; then 1/4/2 packet -> order_err=1, err_cnt=1.
//  - SOP,1,2 then SOP,3,EOP -> first stat len=2 frame_err=1, second len=2 clean; pkt_cnt=2.
//  - 251-beat ascending packet -> len_err=1, stat_len_o=251; 250-beat -> clean.
//  - bp on, 200 random sorted packets with valid held until ready -> no errors, ready duty
//    60-90%, pkt_cnt=200; beats with valid&!ready never counted.
//  - non-SOP beats in IDLE_S -> orphan_cnt increments; rst_ni low mid-packet -> all stats 0,
//    ready=1, no stat_valid_o.

Source files
------------

// File: rtl/avst_pkg.sv
// Shared types and constants for the sorted-packet checker and its backpressure source.
package avst_pkg;

  typedef enum logic {
    IDLE_S = 1'b0,
    RECV_S = 1'b1
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, as a mask over lfsr bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned STAT_LEN_W = 16;

  typedef struct packed {
    logic [STAT_LEN_W-1:0] len;
    logic                  order_err;
    logic                  len_err;
    logic                  frame_err;
  } pkt_stat_t;

endpackage

// File: rtl/bp_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; its two low bits form a ~75% ready pattern.
module bp_lfsr
  import avst_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic bp_ready_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= SEED;
    else         lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  assign bp_ready_o = lfsr_q[1] | lfsr_q[0];

endmodule

// File: rtl/sorted_pkt_checker.sv
// Avalon-ST sink that checks framing, length and non-decreasing order of each packet
// and reports per-packet status plus running packet/error/orphan counters.
module sorted_pkt_checker
  import avst_pkg::*;
#(
  parameter int unsigned DWIDTH      = 16,
  parameter int unsigned MAX_PKT_LEN = 250,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned CWIDTH      = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [DWIDTH-1:0]              snk_data_i,
  input  logic                           snk_startofpacket_i,
  input  logic                           snk_endofpacket_i,
  input  logic                           snk_valid_i,
  output logic                           snk_ready_o,
  input  logic                           cfg_bp_en_i,
  output logic                           stat_valid_o,
  output logic [$clog2(MAX_PKT_LEN):0]   stat_len_o,
  output logic                           stat_order_err_o,
  output logic                           stat_len_err_o,
  output logic                           stat_frame_err_o,
  output logic [CWIDTH-1:0]              pkt_cnt_o,
  output logic [CWIDTH-1:0]              err_cnt_o,
  output logic [CWIDTH-1:0]              orphan_cnt_o
);

  localparam int unsigned LW = $clog2(MAX_PKT_LEN) + 1;
  localparam logic [LW-1:0] LEN_MAX = '1;
  localparam logic [LW-1:0] LEN_LIM = LW'(MAX_PKT_LEN);
  localparam logic [LW-1:0] LEN_ONE = LW'(1);
  localparam logic [STAT_LEN_W-1:0] LEN_CAP = STAT_LEN_W'(LEN_MAX);

  function automatic pkt_stat_t mk_stat(input logic [LW-1:0] len, input logic o,
                                        input logic l, input logic f);
    pkt_stat_t s;
    s.len       = STAT_LEN_W'(len);
    s.order_err = o;
    s.len_err   = l;
    s.frame_err = f;
    return s;
  endfunction

  logic bp_ready;
  logic ready_q;
  logic acc;

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] prev_q, prev_d;
  logic [LW-1:0]     len_q, len_d, len_inc;
  logic              order_q, order_d, lenf_q, lenf_d;
  logic              orphan_inc;

  logic      ev_a_v, ev_b_v, emit_v, pend_q, pend_d;
  pkt_stat_t ev_a, ev_b, emit, pend_stat_q, pend_stat_d, stat_q;
  logic      stat_valid_q;
  logic [CWIDTH-1:0] pkt_cnt_q, err_cnt_q, orphan_cnt_q;

  bp_lfsr #(.SEED(LFSR_SEED)) u_bp_lfsr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .bp_ready_o (bp_ready)
  );

  assign acc     = snk_valid_i & ready_q;
  assign len_inc = (len_q == LEN_MAX) ? len_q : len_q + LEN_ONE;

  // ev_a is the earlier finish of the beat, ev_b only exists for SOP+EOP arriving mid-packet.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    len_d      = len_q;
    order_d    = order_q;
    lenf_d     = lenf_q;
    orphan_inc = 1'b0;
    ev_a_v     = 1'b0;
    ev_a       = '0;
    ev_b_v     = 1'b0;
    ev_b       = '0;
    if (acc) begin
      if (snk_startofpacket_i) begin
        if (state_q == RECV_S) begin
          ev_a_v = 1'b1;
          ev_a   = mk_stat(len_q, order_q, lenf_q, 1'b1);
        end
        prev_d  = snk_data_i;
        len_d   = LEN_ONE;
        order_d = 1'b0;
        lenf_d  = 1'b0;
        if (snk_endofpacket_i) begin
          state_d = IDLE_S;
          if (state_q == RECV_S) begin
            ev_b_v = 1'b1;
            ev_b   = mk_stat(LEN_ONE, 1'b0, 1'b0, 1'b0);
          end else begin
            ev_a_v = 1'b1;
            ev_a   = mk_stat(LEN_ONE, 1'b0, 1'b0, 1'b0);
          end
        end else begin
          state_d = RECV_S;
        end
      end else if (state_q == RECV_S) begin
        prev_d  = snk_data_i;
        len_d   = len_inc;
        order_d = order_q | (snk_data_i < prev_q);
        lenf_d  = lenf_q | (len_inc > LEN_LIM);
        if (snk_endofpacket_i) begin
          state_d = IDLE_S;
          ev_a_v  = 1'b1;
          ev_a    = mk_stat(len_d, order_d, lenf_d, 1'b0);
        end
      end else begin
        orphan_inc = 1'b1;
      end
    end
  end

  // One status leaves per cycle; a held-over second finish always goes out first. While one
  // is held the FSM is idle, so at most one new finish can join it and one slot suffices.
  always_comb begin
    if (pend_q) begin
      emit_v      = 1'b1;
      emit        = pend_stat_q;
      pend_d      = ev_a_v;
      pend_stat_d = ev_a;
    end else begin
      emit_v      = ev_a_v;
      emit        = ev_a;
      pend_d      = ev_b_v;
      pend_stat_d = ev_b;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q      <= 1'b1;
      state_q      <= IDLE_S;
      prev_q       <= '0;
      len_q        <= '0;
      order_q      <= 1'b0;
      lenf_q       <= 1'b0;
      pend_q       <= 1'b0;
      pend_stat_q  <= '0;
      stat_valid_q <= 1'b0;
      stat_q       <= '0;
      pkt_cnt_q    <= '0;
      err_cnt_q    <= '0;
      orphan_cnt_q <= '0;
    end else begin
      ready_q      <= cfg_bp_en_i ? bp_ready : 1'b1;
      state_q      <= state_d;
      prev_q       <= prev_d;
      len_q        <= len_d;
      order_q      <= order_d;
      lenf_q       <= lenf_d;
      pend_q       <= pend_d;
      pend_stat_q  <= pend_stat_d;
      stat_valid_q <= emit_v;
      if (emit_v) stat_q <= emit;
      pkt_cnt_q    <= pkt_cnt_q + CWIDTH'(emit_v);
      err_cnt_q    <= err_cnt_q + CWIDTH'(emit_v & (emit.order_err | emit.len_err | emit.frame_err));
      orphan_cnt_q <= orphan_cnt_q + CWIDTH'(orphan_inc);
    end
  end

  assign snk_ready_o      = ready_q;
  assign stat_valid_o     = stat_valid_q;
  assign stat_len_o       = (stat_q.len > LEN_CAP) ? LEN_MAX : stat_q.len[LW-1:0];
  assign stat_order_err_o = stat_q.order_err;
  assign stat_len_err_o   = stat_q.len_err;
  assign stat_frame_err_o = stat_q.frame_err;
  assign pkt_cnt_o        = pkt_cnt_q;
  assign err_cnt_o        = err_cnt_q;
  assign orphan_cnt_o     = orphan_cnt_q;

endmodule

// File: tb/tb_sorted_pkt_checker.sv
// Directed bench for sorted_pkt_checker: framing, order, length, orphans, reset, backpressure.
module tb_sorted_pkt_checker;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data;
  logic          sop, eop, valid, bp_en;
  logic          ready, stat_valid, order_err, len_err, frame_err;
  logic [8:0]    stat_len;
  logic [CW-1:0] pkt_cnt, err_cnt, orphan_cnt;

  sorted_pkt_checker #(
    .DWIDTH      (DW),
    .MAX_PKT_LEN (250),
    .LFSR_SEED   (16'hACE1),
    .CWIDTH      (CW)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .snk_data_i          (data),
    .snk_startofpacket_i (sop),
    .snk_endofpacket_i   (eop),
    .snk_valid_i         (valid),
    .snk_ready_o         (ready),
    .cfg_bp_en_i         (bp_en),
    .stat_valid_o        (stat_valid),
    .stat_len_o          (stat_len),
    .stat_order_err_o    (order_err),
    .stat_len_err_o      (len_err),
    .stat_frame_err_o    (frame_err),
    .pkt_cnt_o           (pkt_cnt),
    .err_cnt_o           (err_cnt),
    .orphan_cnt_o        (orphan_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int q_len[$];
  int q_flags[$];
  int q_cyc[$];
  bit mon_duty = 1'b0;
  int unsigned duty_cyc = 0, duty_hi = 0;

  always @(posedge clk) begin
    #1;
    if (stat_valid === 1'b1) begin
      q_len.push_back(int'(stat_len));
      q_flags.push_back(int'({order_err, len_err, frame_err}));
      q_cyc.push_back(int'(cyc));
    end
    if (mon_duty) begin
      duty_cyc++;
      if (ready) duty_hi++;
    end
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned acc_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic s, input logic e);
    int unsigned w = 0;
    @(negedge clk);
    data = d; sop = s; eop = e; valid = 1'b1;
    while (!ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!ready) check("ready_wait", 32'(ready), 1);
    acc_cyc = cyc;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_stat(input string tag, input int len, input int flags, output int c);
    c = 0;
    check({tag, "_avail"}, 32'(q_len.size() > 0), 1);
    if (q_len.size() > 0) begin
      check({tag, "_len"}, 32'(q_len.pop_front()), 32'(len));
      check({tag, "_flags"}, 32'(q_flags.pop_front()), 32'(flags));
      c = q_cyc.pop_front();
    end
  endtask

  initial begin
    int c1, c2, c3, e1;
    int exp_lens[$];
    int unsigned pct;
    logic [DW-1:0] d;
    int len;

    rst_n = 1'b0; data = '0; sop = 1'b0; eop = 1'b0; valid = 1'b0; bp_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(ready), 1);
    check("rst_stat_valid", 32'(stat_valid), 0);
    check("rst_stat_len", 32'(stat_len), 0);
    check("rst_flags", 32'({order_err, len_err, frame_err}), 0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_orphan_cnt", 32'(orphan_cnt), 0);

    // 3,5,5,9: equal neighbours are legal
    beat(3, 1, 0); beat(5, 0, 0); beat(5, 0, 0); beat(9, 0, 1);
    e1 = int'(acc_cyc);
    idle(3);
    expect_stat("t1", 4, 0, c1);
    check("t1_latency", 32'(c1 - e1), 1);
    check("t1_pkt_cnt", 32'(pkt_cnt), 1);
    check("t1_err_cnt", 32'(err_cnt), 0);
    check("t1_hold_len", 32'(stat_len), 4);
    check("t1_pulse_1cyc", 32'(stat_valid), 0);

    beat(7, 1, 1);
    beat(1, 1, 0); beat(4, 0, 0); beat(2, 0, 1);
    idle(3);
    expect_stat("t2_single", 1, 0, c1);
    expect_stat("t2_order", 3, 3'b100, c1);
    check("t2_pkt_cnt", 32'(pkt_cnt), 3);
    check("t2_err_cnt", 32'(err_cnt), 1);

    beat(1, 1, 0); beat(2, 0, 0); beat(3, 1, 0); beat(5, 0, 1);
    idle(3);
    expect_stat("t3_trunc", 2, 3'b001, c1);
    expect_stat("t3_next", 2, 0, c1);
    check("t3_pkt_cnt", 32'(pkt_cnt), 5);
    check("t3_err_cnt", 32'(err_cnt), 2);

    // SOP+EOP mid-packet, then an immediate single-beat packet: three back-to-back statuses
    beat(1, 1, 0); beat(2, 0, 0); beat(0, 1, 1); beat(6, 1, 1);
    idle(4);
    expect_stat("t3b_trunc", 2, 3'b001, c1);
    expect_stat("t3b_single", 1, 0, c2);
    expect_stat("t3b_follow", 1, 0, c3);
    check("t3b_gap1", 32'(c2 - c1), 1);
    check("t3b_gap2", 32'(c3 - c2), 1);
    check("t3b_pkt_cnt", 32'(pkt_cnt), 8);
    check("t3b_err_cnt", 32'(err_cnt), 3);

    beat(0, 1, 0);
    for (int i = 1; i < 250; i++) beat(DW'(i), 0, 0);
    beat(250, 0, 1);
    beat(0, 1, 0);
    for (int i = 1; i < 249; i++) beat(DW'(i), 0, 0);
    beat(249, 0, 1);
    idle(3);
    expect_stat("t4_251", 251, 3'b010, c1);
    expect_stat("t4_250", 250, 0, c1);
    check("t4_pkt_cnt", 32'(pkt_cnt), 10);
    check("t4_err_cnt", 32'(err_cnt), 4);

    beat(9, 0, 0); beat(8, 0, 0); beat(7, 0, 1);
    idle(3);
    check("orphan_cnt", 32'(orphan_cnt), 3);
    check("orphan_pkt_cnt", 32'(pkt_cnt), 10);
    check("orphan_no_stat", 32'(q_len.size()), 0);

    beat(1, 1, 0); beat(2, 0, 0);
    @(negedge clk);
    valid = 1'b0; sop = 1'b0; eop = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("mrst_pkt_cnt", 32'(pkt_cnt), 0);
    check("mrst_err_cnt", 32'(err_cnt), 0);
    check("mrst_orphan_cnt", 32'(orphan_cnt), 0);
    check("mrst_ready", 32'(ready), 1);
    check("mrst_stat_len", 32'(stat_len), 0);
    rst_n = 1'b1;
    idle(4);
    check("mrst_no_stat", 32'(q_len.size()), 0);
    beat(3, 0, 1);
    idle(2);
    check("mrst_idle_orphan", 32'(orphan_cnt), 1);

    @(negedge clk);
    bp_en = 1'b1;
    mon_duty = 1'b1;
    for (int p = 0; p < 200; p++) begin
      len = int'($urandom_range(1, 8));
      d = DW'($urandom_range(0, 100));
      exp_lens.push_back(len);
      for (int b = 0; b < len; b++) begin
        beat(d, b == 0, b == len - 1);
        d = d + DW'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(6);
    mon_duty = 1'b0;
    check("bp_stat_count", 32'(q_len.size()), 200);
    while (exp_lens.size() > 0 && q_len.size() > 0) begin
      check("bp_len", 32'(q_len.pop_front()), 32'(exp_lens.pop_front()));
      check("bp_flags", 32'(q_flags.pop_front()), 0);
      void'(q_cyc.pop_front());
    end
    check("bp_pkt_cnt", 32'(pkt_cnt), 200);
    check("bp_err_cnt", 32'(err_cnt), 0);
    check("bp_orphan_cnt", 32'(orphan_cnt), 1);
    pct = (duty_cyc > 0) ? (duty_hi * 100) / duty_cyc : 0;
    check("bp_duty_range", 32'(pct >= 60 && pct <= 90), 1);
    bp_en = 1'b0;
    @(negedge clk);
    check("bp_off_ready", 32'(ready), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
